// File: rtl/matrix_stream_sequencer.sv
// matrix_stream_sequencer
//   Upstream operand feeder for matrixmultiplier. Holds a DIM x DIM float32
//   transform matrix and a two-slot pixel-vector buffer (cur = streaming,
//   nxt = pending). For every accepted pixel it emits the DIM*DIM pairs
//   (M[idx], v[idx % DIM]) in row-major order, one pair per clock, on the
//   multiplier's a/b/a_tvalid/b_tvalid inputs. Back-to-back pixels stream
//   without a bubble. The consumer has no back-pressure and must take one
//   pair per clock.
//
//   The pixel port list (pix_v0..pix_v3) and the 4-bit mat_addr fix DIM at 4.
//
//   Build option: define MATSEQ_PERF_CNT_EN to add the 32-bit pix_count
//   output, which counts completed pixel streams (cycles with seq_last=1).
//   It is cleared by reset and wraps.

module matrix_stream_sequencer #(
    parameter int DATA_W = 32,
    parameter int DIM    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mat_we,
    input  logic [3:0]        mat_addr,
    input  logic [DATA_W-1:0] mat_wdata,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [DATA_W-1:0] pix_v0,
    input  logic [DATA_W-1:0] pix_v1,
    input  logic [DATA_W-1:0] pix_v2,
    input  logic [DATA_W-1:0] pix_v3,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic              a_tvalid,
    output logic              b_tvalid,
    output logic              seq_last,
    output logic              busy
`ifdef MATSEQ_PERF_CNT_EN
    ,
    output logic [31:0]       pix_count
`endif
);

    localparam int LEN   = DIM * DIM;
    localparam int IDX_W = $clog2(LEN);
    localparam int COL_W = $clog2(DIM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] mat    [LEN];
    logic [DATA_W-1:0] cur    [DIM];
    logic [DATA_W-1:0] nxt    [DIM];
    logic              nxt_valid;
    logic [DATA_W-1:0] pix_in [DIM];
    logic              accept;
    logic              last_pair;
    logic              mat_wr_en;

    assign pix_in[0] = pix_v0;
    assign pix_in[1] = pix_v1;
    assign pix_in[2] = pix_v2;
    assign pix_in[3] = pix_v3;

    // A new pixel can always be taken while the pending slot is free.
    assign pix_ready = !nxt_valid;
    assign accept    = pix_valid && pix_ready;
    assign busy      = (state == STREAM) || nxt_valid;
    assign last_pair = (idx == LAST_IDX);

    // The matrix is only writable while nothing is streaming or pending, so a
    // stream never sees a half-updated matrix. A write in the same IDLE cycle
    // as a pixel accept lands before that pixel's first read.
    assign mat_wr_en = mat_we && (state == IDLE) && !nxt_valid;

    // Matrix storage: cleared on reset, written only when idle.
    // NOTE: this array is reset to zero, so it maps to flops rather than a RAM
    // macro; at 16 words that is cheap and gives a defined power-up matrix.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LEN; i++) begin
                mat[i] <= '0;
            end
        end else if (mat_wr_en) begin
            mat[mat_addr] <= mat_wdata;
        end
    end

    // Sequencer FSM: pixel buffering, stream index and registered operand outputs.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, e.g. cur[idx] and the idx increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            nxt_valid <= 1'b0;
            a         <= '0;
            b         <= '0;
            a_tvalid  <= 1'b0;
            b_tvalid  <= 1'b0;
            seq_last  <= 1'b0;
            for (int i = 0; i < DIM; i++) begin
                cur[i] <= '0;
                nxt[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    // a and b keep their last values; only the qualifiers drop.
                    a_tvalid <= 1'b0;
                    b_tvalid <= 1'b0;
                    seq_last <= 1'b0;
                    if (accept) begin
                        for (int i = 0; i < DIM; i++) begin
                            cur[i] <= pix_in[i];
                        end
                        idx   <= '0;
                        state <= STREAM;
                    end
                end

                STREAM: begin
                    a        <= mat[idx];
                    b        <= cur[idx[COL_W-1:0]];
                    a_tvalid <= 1'b1;
                    b_tvalid <= 1'b1;
                    seq_last <= last_pair;
                    if (last_pair) begin
                        idx <= '0;
                        if (nxt_valid) begin
                            // Pending pixel takes over with no gap.
                            for (int i = 0; i < DIM; i++) begin
                                cur[i] <= nxt[i];
                            end
                            nxt_valid <= 1'b0;
                        end else if (accept) begin
                            // Pixel arriving on the final pair skips the
                            // pending slot and streams next cycle.
                            for (int i = 0; i < DIM; i++) begin
                                cur[i] <= pix_in[i];
                            end
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        idx <= idx + IDX_W'(1);
                        if (accept) begin
                            for (int i = 0; i < DIM; i++) begin
                                nxt[i] <= pix_in[i];
                            end
                            nxt_valid <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MATSEQ_PERF_CNT_EN
    // Completed-pixel counter: one increment per cycle with seq_last high.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_count <= '0;
        end else if (seq_last) begin
            pix_count <= pix_count + 32'd1;
        end
    end
`endif

endmodule
